// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port between instruction fetch (IF) and
// the load/store unit (LS). One requester is granted at a time. Its command
// is registered and presented to memory, and the response is routed back to
// the owner.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   if_req/if_addr    fetch request and address; if_gnt grant (comb)
//   if_rvalid/rdata   fetch response (comb pass-through of memory response)
//   ls_req/we/addr/wdata/wstrb  load/store request; ls_gnt grant (comb)
//   ls_rvalid/rdata   load data or store-complete (comb pass-through)
//   mem_req/we/addr/wdata/wstrb registered command to memory
//   mem_ready         memory accepts the command this cycle
//   mem_rvalid/rdata  memory response or write-ack
//   sel               current owner, drives the address/data mux (0=IF, 1=LS)
//   busy              high whenever the sequencer is not idle
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                sel,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;        // 1 = LS was granted last
  logic                sel_q, sel_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

  logic                win_ls_s;
  logic                grant_ok_s;
  logic                resp_hit_s;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    win_ls_s = 1'b0;
    if (ls_req) begin
      if (if_req) begin
        win_ls_s = ~last_q;
      end else begin
        win_ls_s = 1'b1;
      end
    end else begin
      win_ls_s = 1'b0;
    end
  end

  // Grants only exist in IDLE; rst_n gating keeps them low while reset is held.
  assign grant_ok_s = rst_n && (state_q == ST_IDLE);
  assign if_gnt     = grant_ok_s && if_req && !win_ls_s;
  assign ls_gnt     = grant_ok_s && win_ls_s;

  // A response only counts in RESP; stray mem_rvalid elsewhere is dropped.
  assign resp_hit_s = (state_q == ST_RESP) && mem_rvalid;
  assign if_rvalid  = resp_hit_s && !sel_q;
  assign ls_rvalid  = resp_hit_s && sel_q;
  assign if_rdata   = mem_rdata;
  assign ls_rdata   = mem_rdata;

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign sel        = sel_q;
  assign busy       = busy_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    busy_d      = busy_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          state_d   = ST_CMD;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          sel_d     = win_ls_s;
          last_d    = win_ls_s;
          if (win_ls_s) begin
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_wstrb_d = ls_wstrb;
          end else begin
            // Fetches are always reads with no byte lanes enabled.
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DATA_W{1'b0}};
            mem_wstrb_d = {STRB_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (mem_ready) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and command registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_wstrb_q <= {STRB_W{1'b0}};
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of per-cycle vectors with expected
// outputs, an expectation queue popped at each sampling point, a response
// scoreboard for rvalid/rdata, and a hand-written reset-abort sequence.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sel, busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;       // {if_req, ls_req}
    logic        we;
    logic [31:0] ia, la, wd;
    logic [3:0]  ws;
    logic        rdy, rv;
    logic [31:0] rd;
    logic [1:0]  e_gnt;     // {if_gnt, ls_gnt}
    logic        e_mreq, e_sel, e_busy;
    logic [1:0]  e_rv;      // {if_rvalid, ls_rvalid}
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
  } vec_t;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
  } rsp_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] req, input logic we, input logic [31:0] ia,
                     input logic [31:0] la, input logic [31:0] wd, input logic [3:0] ws,
                     input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic [1:0] e_gnt, input logic e_mreq, input logic e_sel,
                     input logic e_busy, input logic [1:0] e_rv, input logic e_we,
                     input logic [31:0] e_addr, input logic [3:0] e_strb);
    vec_t v;
    v.req = req; v.we = we; v.ia = ia; v.la = la; v.wd = wd; v.ws = ws;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_gnt = e_gnt; v.e_mreq = e_mreq; v.e_sel = e_sel; v.e_busy = e_busy;
    v.e_rv = e_rv; v.e_we = e_we; v.e_addr = e_addr; v.e_strb = e_strb;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rsp_t r;
    {if_req, ls_req} = v.req;
    ls_we = v.we; if_addr = v.ia; ls_addr = v.la; ls_wdata = v.wd; ls_wstrb = v.ws;
    mem_ready = v.rdy; mem_rvalid = v.rv; mem_rdata = v.rd;
    exp_q.push_back(v);
    if (v.e_rv != 2'b00) begin
      r.is_ls = v.e_rv[0];
      r.data  = v.rd;
      rsp_q.push_back(r);
    end
  endtask

  task automatic compare(input int i);
    vec_t e;
    rsp_t r;
    string p;
    p = $sformatf("v%0d", i);
    if (exp_q.size() == 0) begin
      chk({p, " exp_q_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({p, " gnt"},      {30'd0, if_gnt, ls_gnt}, {30'd0, e.e_gnt});
    chk({p, " mem_req"},  {31'd0, mem_req}, {31'd0, e.e_mreq});
    chk({p, " sel"},      {31'd0, sel}, {31'd0, e.e_sel});
    chk({p, " busy"},     {31'd0, busy}, {31'd0, e.e_busy});
    chk({p, " rvalid"},   {30'd0, if_rvalid, ls_rvalid}, {30'd0, e.e_rv});
    chk({p, " mem_we"},   {31'd0, mem_we}, {31'd0, e.e_we});
    chk({p, " mem_addr"}, mem_addr, e.e_addr);
    chk({p, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, e.e_strb});
    chk({p, " if_rdata"}, if_rdata, e.rd);
    chk({p, " ls_rdata"}, ls_rdata, e.rd);
    if (if_rvalid || ls_rvalid) begin
      if (rsp_q.size() == 0) begin
        chk({p, " unexpected_rvalid"}, 32'd1, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk({p, " rsp_owner"}, {31'd0, ls_rvalid}, {31'd0, r.is_ls});
        chk({p, " rsp_data"}, ls_rvalid ? ls_rdata : if_rdata, r.data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_wstrb = 4'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // Single fetch
    add(2'b10,1'b0,32'h100,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,        2'b10,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,4'h0);
    add(2'b00,1'b0,32'h100,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,        2'b00,1'b1,1'b0,1'b1,2'b00,1'b0,32'h100,4'h0);
    add(2'b00,1'b0,32'h100,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h13,       2'b00,1'b0,1'b0,1'b1,2'b10,1'b0,32'h100,4'h0);
    // Store with three wait states
    add(2'b01,1'b1,32'h100,32'h2000,32'hDEADBEEF,4'hF, 1'b0,1'b0,32'h0, 2'b01,1'b0,1'b0,1'b0,2'b00,1'b0,32'h100,4'h0);
    for (int k = 0; k < 4; k++) begin
      add(2'b00,1'b1,32'h100,32'h2000,32'hDEADBEEF,4'hF, (k == 3),1'b0,32'h0, 2'b00,1'b1,1'b1,1'b1,2'b00,1'b1,32'h2000,4'hF);
    end
    add(2'b00,1'b1,32'h100,32'h2000,32'hDEADBEEF,4'hF, 1'b0,1'b1,32'hCAFEF00D, 2'b00,1'b0,1'b1,1'b1,2'b01,1'b1,32'h2000,4'hF);
    // Stray mem_rvalid in IDLE
    add(2'b00,1'b0,32'h100,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h12345678, 2'b00,1'b0,1'b1,1'b0,2'b00,1'b1,32'h2000,4'hF);
    // Tie round-robin: IF, LS, IF, LS (stray rvalid in CMD at v11)
    add(2'b11,1'b0,32'h200,32'h3000,32'h0,4'h0, 1'b0,1'b0,32'h0,     2'b10,1'b0,1'b1,1'b0,2'b00,1'b1,32'h2000,4'hF);
    add(2'b11,1'b0,32'h200,32'h3000,32'h0,4'h0, 1'b1,1'b1,32'h55,    2'b00,1'b1,1'b0,1'b1,2'b00,1'b0,32'h200,4'h0);
    add(2'b11,1'b0,32'h200,32'h3000,32'h0,4'h0, 1'b0,1'b1,32'hAAAA5555, 2'b00,1'b0,1'b0,1'b1,2'b10,1'b0,32'h200,4'h0);
    add(2'b11,1'b0,32'h200,32'h3000,32'h0,4'h0, 1'b0,1'b0,32'h0,     2'b01,1'b0,1'b0,1'b0,2'b00,1'b0,32'h200,4'h0);
    add(2'b11,1'b0,32'h200,32'h3000,32'h0,4'h0, 1'b1,1'b0,32'h0,     2'b00,1'b1,1'b1,1'b1,2'b00,1'b0,32'h3000,4'h0);
    add(2'b11,1'b0,32'h200,32'h3000,32'h0,4'h0, 1'b0,1'b1,32'h11,    2'b00,1'b0,1'b1,1'b1,2'b01,1'b0,32'h3000,4'h0);
    add(2'b11,1'b0,32'h204,32'h3000,32'h0,4'h0, 1'b0,1'b0,32'h0,     2'b10,1'b0,1'b1,1'b0,2'b00,1'b0,32'h3000,4'h0);
    add(2'b11,1'b0,32'h204,32'h3000,32'h0,4'h0, 1'b1,1'b0,32'h0,     2'b00,1'b1,1'b0,1'b1,2'b00,1'b0,32'h204,4'h0);
    add(2'b11,1'b0,32'h204,32'h3000,32'h0,4'h0, 1'b0,1'b1,32'h22,    2'b00,1'b0,1'b0,1'b1,2'b10,1'b0,32'h204,4'h0);
    add(2'b11,1'b0,32'h204,32'h3000,32'h0,4'h0, 1'b0,1'b0,32'h0,     2'b01,1'b0,1'b0,1'b0,2'b00,1'b0,32'h204,4'h0);
    add(2'b00,1'b0,32'h204,32'h3000,32'h0,4'h0, 1'b1,1'b0,32'h0,     2'b00,1'b1,1'b1,1'b1,2'b00,1'b0,32'h3000,4'h0);
    add(2'b00,1'b0,32'h204,32'h3000,32'h0,4'h0, 1'b0,1'b1,32'h33,    2'b00,1'b0,1'b1,1'b1,2'b01,1'b0,32'h3000,4'h0);
    // LS request arriving while an IF transaction is in flight
    add(2'b10,1'b0,32'h300,32'h4000,32'h0,4'h0, 1'b0,1'b0,32'h0,     2'b10,1'b0,1'b1,1'b0,2'b00,1'b0,32'h3000,4'h0);
    add(2'b01,1'b0,32'h300,32'h4000,32'h0,4'h0, 1'b1,1'b0,32'h0,     2'b00,1'b1,1'b0,1'b1,2'b00,1'b0,32'h300,4'h0);
    add(2'b01,1'b0,32'h300,32'h4000,32'h0,4'h0, 1'b0,1'b1,32'h44,    2'b00,1'b0,1'b0,1'b1,2'b10,1'b0,32'h300,4'h0);
    add(2'b01,1'b0,32'h300,32'h4000,32'h0,4'h0, 1'b0,1'b0,32'h0,     2'b01,1'b0,1'b0,1'b0,2'b00,1'b0,32'h300,4'h0);
    add(2'b00,1'b0,32'h300,32'h4000,32'h0,4'h0, 1'b1,1'b0,32'h0,     2'b00,1'b1,1'b1,1'b1,2'b00,1'b0,32'h4000,4'h0);
    add(2'b00,1'b0,32'h300,32'h4000,32'h0,4'h0, 1'b0,1'b1,32'h55,    2'b00,1'b0,1'b1,1'b1,2'b01,1'b0,32'h4000,4'h0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset sel",     {31'd0, sel}, 32'd0);
    chk("reset busy",    {31'd0, busy}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset gnt",     {30'd0, if_gnt, ls_gnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      compare(i);
      @(posedge clk); #1;
    end

    // Reset mid-transaction: IF granted last, then aborted in CMD
    if_req = 1'b1; ls_req = 1'b0; if_addr = 32'h400; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("abort if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("abort in_cmd mem_req", {31'd0, mem_req}, 32'd1);
    chk("abort in_cmd mem_addr", mem_addr, 32'h400);
    #2;
    rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    #1;
    chk("abort async mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort async busy",    {31'd0, busy}, 32'd0);
    chk("abort async sel",     {31'd0, sel}, 32'd0);
    chk("abort async mem_addr", mem_addr, 32'd0);
    chk("abort async gnt",     {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk("abort async rvalid",  {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    @(negedge clk);
    chk("late rvalid ignored", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    chk("late rvalid busy",    {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h5000;
    @(negedge clk);
    chk("post-reset tie gnt", {30'd0, if_gnt, ls_gnt}, 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk("post-reset tie sel", {31'd0, sel}, 32'd0);
    chk("post-reset mem_addr", mem_addr, 32'h400);
    chk("rsp scoreboard drained", rsp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
